// File: rtl/reg_save_restore_pkg.sv
// Shared types for the register-file save/restore sequencer.
// Holds the FSM state encoding and the transfer-direction constants that
// the top module compares against when it latches a request.
package reg_save_restore_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_RD,
    SAVE_WR,
    RST_RD,
    RST_WR,
    DONE
  } state_t;

  localparam logic MODE_SAVE    = 1'b0;
  localparam logic MODE_RESTORE = 1'b1;

endpackage

// File: rtl/reg_save_restore.sv
// Register-file save/restore sequencer.
// Save:    walks r0..r(2**D-1) through the RF read port and writes each word
//          to data memory at base, base+1, ... (address wraps mod 2**A).
// Restore: reads the same memory window back and writes it into the RF.
// Ports:
//   clk, init_n             clock and asynchronous active-low reset
//   start, mode, base_addr  request; mode/base latched on the accepted start
//   busy, done              transfer in progress / one-cycle completion pulse
//   rf_raddr, rf_rdata      RF read port (combinational read data)
//   rf_we, rf_waddr, rf_wdata  RF write port
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack
//                           memory request/ack handshake
// Every output is a flop loaded from the next-state decode, so there is no
// combinational path from mem_ack (or any other input) to an output.
module reg_save_restore
  import reg_save_restore_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3,
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         init_n,
  input  logic         start,
  input  logic         mode,
  input  logic [A-1:0] base_addr,
  output logic         busy,
  output logic         done,
  output logic [D-1:0] rf_raddr,
  input  logic [W-1:0] rf_rdata,
  output logic         rf_we,
  output logic [D-1:0] rf_waddr,
  output logic [W-1:0] rf_wdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack
);

  localparam logic [D-1:0] IDX_LAST = '1;

  state_t       state_q, state_d;
  logic [D-1:0] idx_q, idx_d;
  logic [W-1:0] buf_q, buf_d;
  logic [A-1:0] base_q, base_d;
  logic         mode_q, mode_d;

  logic         req_d;
  logic         rfwe_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    base_d  = base_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          base_d  = base_addr;
          idx_d   = '0;
          state_d = (mode == MODE_SAVE) ? SAVE_RD : RST_RD;
        end
      end
      SAVE_RD: begin
        buf_d   = rf_rdata;
        state_d = SAVE_WR;
      end
      SAVE_WR: begin
        if (mem_ack) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + D'(1);
            state_d = SAVE_RD;
          end
        end
      end
      RST_RD: begin
        if (mem_ack) begin
          buf_d   = mem_rdata;
          state_d = RST_WR;
        end
      end
      RST_WR: begin
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + D'(1);
          state_d = RST_RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the state being entered; registered below so each
  // output lines up with the state it belongs to.
  assign req_d  = (state_d == SAVE_WR) || (state_d == RST_RD);
  assign rfwe_d = (state_d == RST_WR);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      buf_q     <= '0;
      base_q    <= '0;
      mode_q    <= MODE_SAVE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rf_raddr  <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      base_q    <= base_d;
      mode_q    <= mode_d;
      busy      <= (state_d != IDLE) && (state_d != DONE);
      done      <= (state_d == DONE);
      rf_raddr  <= (state_d == SAVE_RD) ? idx_d : '0;
      rf_we     <= rfwe_d;
      rf_waddr  <= rfwe_d ? idx_d : '0;
      rf_wdata  <= rfwe_d ? buf_d : '0;
      mem_req   <= req_d;
      mem_we    <= req_d && (mode_d == MODE_SAVE);
      // Address sum is truncated to A bits, so it wraps past 2**A-1.
      mem_addr  <= req_d ? A'(base_d + A'(idx_d)) : '0;
      mem_wdata <= (state_d == SAVE_WR) ? buf_d : '0;
    end
  end

endmodule

// File: tb/tb_reg_save_restore.sv
module tb_reg_save_restore;

  logic       clk = 1'b0;
  logic       init_n = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic       busy, done;
  logic [2:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ack;

  reg_save_restore #(.W(8), .D(3), .A(8)) dut (
    .clk(clk), .init_n(init_n), .start(start), .mode(mode),
    .base_addr(base_addr), .busy(busy), .done(done),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Environment: register file and memory models plus a wait-state responder.
  logic [7:0] rf_mem [8];
  logic [7:0] mem [256];
  int         wait_cfg = 0;
  bit         ack_hold = 1'b0;
  int         wcnt = 0;
  int         hs_cnt = 0;
  logic [7:0] wlog_a[$], wlog_d[$];
  logic [2:0] rlog_a[$];
  logic [7:0] rlog_d[$];

  assign rf_rdata  = rf_mem[rf_raddr];
  assign mem_rdata = mem[mem_addr];
  always_comb mem_ack = ack_hold | (mem_req & (wcnt >= wait_cfg));

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (init_n && mem_req && mem_ack) begin
      hs_cnt++;
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wlog_a.push_back(mem_addr);
        wlog_d.push_back(mem_wdata);
      end
    end
    if (init_n && rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
      rlog_a.push_back(rf_waddr);
      rlog_d.push_back(rf_wdata);
    end
  end

  // Cycle-level model: cycle n is the interval after the (n-1)th edge
  // following the start edge; busy spans cycles 1..lat-1, done is cycle lat.
  int  cyc = 0;
  int  cs = -1000;
  int  lat = 0;
  bit  mon_en = 1'b0;
  bit  prev_rfwe = 1'b0;
  int  done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && init_n) begin
      int  rel;
      bit  eb, ed;
      rel = cyc - cs;
      eb  = (rel >= 1) && (rel < lat);
      ed  = (rel == lat);
      check("busy", busy, eb);
      check("done", done, ed);
      if (!eb) begin
        check("idle_mem_req", mem_req, 0);
        check("idle_rf_we", rf_we, 0);
      end
      check("req_and_rfwe", mem_req & rf_we, 0);
      check("rfwe_single", rf_we & prev_rfwe, 0);
      prev_rfwe = rf_we;
      if (done) done_cnt++;
    end
  end

  task automatic run(input logic m, input logic [7:0] b, input int waits,
                     input bit hold, input bit repulse, input int exp_lat);
    int done_rel;
    @(negedge clk);
    wait_cfg = hold ? 0 : waits;
    ack_hold = hold;
    mode = m;
    base_addr = b;
    start = 1'b1;
    wlog_a.delete(); wlog_d.delete(); rlog_a.delete(); rlog_d.delete();
    hs_cnt = 0;
    done_cnt = 0;
    done_rel = -1;
    lat = 17 + (hold ? 0 : 8 * waits);
    cs = cyc;
    mon_en = 1'b1;
    for (int i = 0; i < lat + 30; i++) begin
      @(negedge clk);
      start = repulse && ((cyc - cs) == 3 || (cyc - cs) == 9 || (cyc - cs) == lat);
      mode = ~m;
      base_addr = ~b;
      if (done && done_rel < 0) done_rel = cyc - cs;
    end
    start = 1'b0;
    ack_hold = 1'b0;
    check("done_latency", done_rel, exp_lat);
    check("done_count", done_cnt, 1);
    check("handshakes", hs_cnt, 8);
  endtask

  task automatic check_save(input logic [7:0] b);
    check("save_wr_count", wlog_a.size(), 8);
    check("save_rf_untouched", rlog_a.size(), 0);
    for (int i = 0; i < 8 && i < wlog_a.size(); i++) begin
      logic [7:0] ea;
      ea = b + 8'(i);
      check($sformatf("save_addr%0d", i), wlog_a[i], ea);
      check($sformatf("save_data%0d", i), wlog_d[i], rf_mem[i]);
    end
  endtask

  task automatic check_restore(input logic [7:0] b);
    check("rst_wr_count", rlog_a.size(), 8);
    check("rst_mem_untouched", wlog_a.size(), 0);
    for (int i = 0; i < 8 && i < rlog_a.size(); i++) begin
      logic [7:0] ea;
      ea = b + 8'(i);
      check($sformatf("rst_waddr%0d", i), rlog_a[i], i);
      check($sformatf("rst_wdata%0d", i), rlog_d[i], mem[ea]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rf_mem[i] = 8'h10 + 8'(i);
      mem[8'h80 + i] = 8'hA0 + 8'(i);
    end

    // Reset state
    #3 init_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_addrs", {rf_raddr, rf_waddr, mem_addr}, 0);
    check("rst_data", {rf_wdata, mem_wdata}, 0);
    init_n = 1'b1;
    repeat (2) @(negedge clk);

    // Save, zero-wait
    run(1'b0, 8'h40, 0, 1'b0, 1'b0, 17);
    check_save(8'h40);
    check("lit_mem40", mem[8'h40], 8'h10);
    check("lit_mem47", mem[8'h47], 8'h17);

    // Restore, two wait cycles per request
    run(1'b1, 8'h80, 2, 1'b0, 1'b0, 33);
    check_restore(8'h80);
    check("lit_rf0", rf_mem[0], 8'hA0);
    check("lit_rf7", rf_mem[7], 8'hA7);

    // Address wrap
    run(1'b0, 8'hFC, 0, 1'b0, 1'b0, 17);
    check_save(8'hFC);
    if (wlog_a.size() == 8) begin
      check("lit_wrap3", wlog_a[3], 8'hFF);
      check("lit_wrap4", wlog_a[4], 8'h00);
      check("lit_wrap7", wlog_a[7], 8'h03);
    end
    check("lit_mem00", mem[8'h00], 8'hA4);

    // start re-pulsed during busy and in DONE
    run(1'b0, 8'h20, 0, 1'b0, 1'b1, 17);
    check_save(8'h20);

    // mem_ack held high continuously
    run(1'b0, 8'h60, 0, 1'b1, 1'b0, 17);
    check_save(8'h60);

    // Asynchronous reset during RST_RD with mem_req high
    mon_en = 1'b0;
    rlog_a.delete(); rlog_d.delete();
    @(negedge clk);
    wait_cfg = 5;
    mode = 1'b1;
    base_addr = 8'h80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_req", mem_req, 1);
    check("pre_rst_we", mem_we, 0);
    #2 init_n = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_busy", busy, 0);
    check("arst_rf_we", rf_we, 0);
    @(negedge clk);
    init_n = 1'b1;
    wait_cfg = 0;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_req", mem_req, 0);
      check("post_rst_done", done, 0);
    end
    check("post_rst_no_rfwr", rlog_a.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_save_restore.md
Name: reg_save_restore

Overview:
- Sequencer on the opposite side of the register file's ports from the datapath.
- Save mode: walks all 2**D registers through a read port and streams them into data memory at consecutive addresses from a base.
- Restore mode: reads memory back and drives the register-file write port.
- Used for context save/restore around traps and for bench register dumps.

Parameters:
- W, 8, data path width (register and memory word).
- D, 3, register pointer width; 2**D registers handled.
- A, 8, data memory address width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- init_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- mode  in  1  0 = save (RF->mem), 1 = restore (mem->RF); latched with start.
- base_addr  in  A  first memory address; latched with start.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse on completion.
- rf_raddr  out  D  register file read pointer.
- rf_rdata  in  W  register file combinational read data.
- rf_we  out  1  register file write enable.
- rf_waddr  out  D  register file write pointer.
- rf_wdata  out  W  register file write data.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write request, 0 = read request; valid with mem_req.
- mem_addr  out  A  memory address; valid with mem_req.
- mem_wdata  out  W  memory write data; valid with mem_req and mem_we.
- mem_rdata  in  W  memory read data; valid in the mem_ack cycle.
- mem_ack  in  1  completes the current request; may arrive in the same cycle as mem_req.

Behaviour:
- Reset is asynchronous and active-low on init_n; the clock is clk.
- Reset values:
  - State IDLE, idx 0, data buffer 0.
  - busy, done, rf_we, mem_req, mem_we all 0.
  - All address and data outputs 0.
- Reset asserted mid-transfer aborts immediately:
  - No further rf_we or mem_req is issued.
  - Partial memory/RF contents are left as already written.
- States and transitions:
  - IDLE:
    - start=1: latch mode and base_addr, idx<=0.
    - Go to SAVE_RD if mode=0, else RST_RD.
    - start=0: stay in IDLE.
  - SAVE_RD:
    - rf_raddr=idx.
    - Capture rf_rdata into buf at the clock edge, then go to SAVE_WR.
  - SAVE_WR:
    - mem_req=1, mem_we=1, mem_addr=base+idx, mem_wdata=buf.
    - Stay until mem_ack.
    - On ack: if idx==2**D-1 go to DONE, else idx++ and go to SAVE_RD.
  - RST_RD:
    - mem_req=1, mem_we=0, mem_addr=base+idx.
    - Stay until mem_ack.
    - On ack: capture mem_rdata into buf, go to RST_WR.
  - RST_WR:
    - rf_we=1, rf_waddr=idx, rf_wdata=buf, for exactly one cycle.
    - If idx==2**D-1 go to DONE, else idx++ and go to RST_RD.
  - DONE: done=1 for one cycle, then IDLE.
- Output timing:
  - busy=1 in every state except IDLE and DONE.
  - mem_req, mem_we, mem_addr, mem_wdata, rf_we, rf_waddr, rf_wdata are decoded from registered state only; no combinational path from mem_ack to any output.
  - In non-driving states, rf_raddr, rf_waddr, rf_wdata, mem_addr and mem_wdata are 0.
- Address arithmetic: mem_addr = (base + idx) mod 2**A; wraps silently past 2**A-1.
- Latency with ack in the same cycle as req:
  - Save: 2 cycles per register; done pulses 2*2**D+1 cycles after the start edge (17 for D=3).
  - Restore: same figures (2 cycles per register, done at 17 for D=3).
  - Each wait cycle on mem_ack adds one cycle.
- start while busy or in DONE is ignored; it is not queued.
- mode and base_addr changes after the start edge have no effect.
- The block never asserts mem_req and rf_we in the same cycle.

Decomposition:
- Package reg_save_restore_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, SAVE_RD, SAVE_WR, RST_RD, RST_WR, DONE}.
  - localparam MODE_SAVE=1'b0, MODE_RESTORE=1'b1.
- Single flat module: one FSM, idx counter, buf register and latched base/mode.
- No sub-module is warranted.

Test Plan:
- Save, zero-wait memory: RF preloaded r0..r7 = 8'h10..8'h17, base=8'h40, mode=0, start pulse.
  - Memory writes 0x40..0x47 = 0x10..0x17, in order.
  - done pulses exactly 17 cycles after the start edge; busy high for cycles 1..16.
- Restore with waits: memory 0x80..0x87 = 0xA0..0xA7, mode=1, mem_ack delayed 2 cycles per request.
  - RF r0..r7 = 0xA0..0xA7.
  - Each rf_we is a single-cycle pulse.
  - done arrives 17+16 = 33 cycles after the start edge.
- Address wrap: base=8'hFC, save.
  - Writes go to 0xFC, 0xFD, 0xFE, 0xFF, 0x00, 0x01, 0x02, 0x03.
- start re-pulsed at cycles 3 and 9 during a save, and in the DONE cycle.
  - Exactly one transfer occurs and exactly one done pulse.
- Async reset: init_n low mid-cycle during RST_RD with mem_req high.
  - mem_req, busy, rf_we drop immediately (before the next clk edge).
  - After release the block sits in IDLE until the next start.
- mem_ack held high continuously.
  - Save still advances at 2 cycles per register.
  - No duplicate writes; exactly 8 mem_req-with-ack handshakes.
